// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Round-robin write arbiter and flush sequencer sitting in front of the
// 4-bit-in / 32-bit-out flushable FIFO. Producers win the FIFO write port in
// atomic bursts of BEATS nibbles, so every 32-bit word read out of the FIFO
// comes from a single producer. The block also owns the FIFO flush
// handshake: a system flush request waits for the in-flight burst to finish,
// then flush_req is held until the FIFO answers with flush_done.
//
// Optional feature: define FLUSH_TIMEOUT_EN to bound the wait for
// flush_done to TIMEOUT_CYC cycles. On expiry, flush_err is set (sticky
// until reset) and the flush sequence ends as if flush_done had arrived.
// Without the macro, FLUSH waits indefinitely and flush_err is tied low.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous reset, active-low
//   req         per-producer request, a full word is ready
//   req_data    per-producer nibble, producer i at [i*WR_WIDTH +: WR_WIDTH]
//   gnt         one-hot registered grant, high for the whole burst
//   beat_take   gnt & wr, producer advances to its next nibble
//   wr          FIFO write enable
//   wr_data     nibble of the granted producer
//   full        FIFO full
//   flush_in    system flush request (level or pulse)
//   flush_req   FIFO flush request
//   flush_done  FIFO flush completed
//   flush_ack   one-cycle pulse, flush sequence finished
//   busy        arbiter is not idle
//   flush_err   sticky flush timeout flag
//   state_dbg   current FSM state (IDLE=0, BURST=1, FLUSH=2)
//
// Handshake: a producer raises req[i] once its whole word is ready and holds
// it, with the current nibble on its req_data slice, until gnt[i]. During
// the burst each cycle with beat_take[i]=1 consumes the presented nibble;
// the producer then shows its next nibble on the following cycle. A cycle
// with gnt[i]=1 and beat_take[i]=0 (FIFO full) consumes nothing.

module fifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WR_WIDTH    = 4,
    parameter int RD_WIDTH    = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WR_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           beat_take,
    output logic                         wr,
    output logic [WR_WIDTH-1:0]          wr_data,
    input  logic                         full,
    input  logic                         flush_in,
    output logic                         flush_req,
    input  logic                         flush_done,
    output logic                         flush_ack,
    output logic                         busy,
    output logic                         flush_err,
    output logic [1:0]                   state_dbg
);

    localparam int BEATS = RD_WIDTH / WR_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    beat_cnt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    cand;
    logic                pick_vld;
    logic                flush_pending;
    logic                flush_ack_q;
    logic                flush_fin;
    logic                flush_timeout;
    logic                last_beat;
    logic [WR_WIDTH-1:0] lane [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane[g] = req_data[g*WR_WIDTH +: WR_WIDTH];
    end

    // Round-robin search starting just after the last burst owner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign wr        = (state == S_BURST) && !full;
    assign wr_data   = lane[gnt_idx];
    assign beat_take = gnt & {NUM_REQ{wr}};
    assign last_beat = wr && (beat_cnt == LAST_BEAT);
    assign flush_req = (state == S_FLUSH);
    assign flush_fin = (state == S_FLUSH) && (flush_done || flush_timeout);
    assign flush_ack = flush_ack_q;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            gnt           <= '0;
            gnt_idx       <= '0;
            beat_cnt      <= '0;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            flush_pending <= 1'b0;
            flush_ack_q   <= 1'b0;
        end else begin
            flush_ack_q <= flush_fin;
            // A flush_in on the finishing cycle re-arms: set wins over clear.
            flush_pending <= flush_in || (flush_pending && !flush_fin);

            case (state)
                S_IDLE: begin
                    // Flush beats requests; a flush_in seen this very cycle counts.
                    if (flush_pending || flush_in) begin
                        state <= S_FLUSH;
                    end else if (pick_vld) begin
                        state    <= S_BURST;
                        gnt      <= NUM_REQ'(1) << pick_idx;
                        gnt_idx  <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (wr) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (last_beat) begin
                        state  <= S_IDLE;
                        gnt    <= '0;
                        rr_ptr <= gnt_idx;
                    end
                end
                S_FLUSH: begin
                    if (flush_fin) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

`ifdef FLUSH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             flush_err_q;

    // Counts cycles spent in FLUSH; the TIMEOUT_CYC-th cycle without
    // flush_done ends the sequence.
    assign flush_timeout = (state == S_FLUSH) && !flush_done && (tmo_cnt == TMO_LAST);
    assign flush_err     = flush_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt     <= '0;
            flush_err_q <= 1'b0;
        end else begin
            if ((state == S_FLUSH) && !flush_fin) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (flush_timeout) begin
                flush_err_q <= 1'b1;
            end
        end
    end
`else
    assign flush_timeout = 1'b0;
    // No timeout hardware: the flag is constant low whatever TIMEOUT_CYC is.
    assign flush_err     = 1'b0 & (TIMEOUT_CYC > 0);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int WR_WIDTH    = 4;
    localparam int RD_WIDTH    = 32;
    localparam int TIMEOUT_CYC = 16;
    localparam int BEATS       = RD_WIDTH / WR_WIDTH;
    localparam int CAP         = 128;
`ifdef FLUSH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic [NUM_REQ-1:0]          req = '0;
    logic [NUM_REQ*WR_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          beat_take;
    logic                        wr;
    logic [WR_WIDTH-1:0]         wr_data;
    logic                        full = 1'b0;
    logic                        flush_in = 1'b0;
    logic                        flush_req;
    logic                        flush_done = 1'b0;
    logic                        flush_ack;
    logic                        busy;
    logic                        flush_err;
    logic [1:0]                  state_dbg;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .WR_WIDTH(WR_WIDTH),
        .RD_WIDTH(RD_WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .beat_take(beat_take), .wr(wr), .wr_data(wr_data),
        .full(full), .flush_in(flush_in), .flush_req(flush_req),
        .flush_done(flush_done), .flush_ack(flush_ack), .busy(busy),
        .flush_err(flush_err), .state_dbg(state_dbg)
    );

    initial begin
        #900_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- producers ----------------
    logic [RD_WIDTH-1:0] words [NUM_REQ][CAP];
    int head [NUM_REQ];
    int tail [NUM_REQ];
    int beat [NUM_REQ];

    task automatic add_word(input int i, input logic [RD_WIDTH-1:0] w);
        if (tail[i] < CAP) begin
            words[i][tail[i]] = w;
            tail[i]++;
        end
    endtask

    // ---------------- scoreboard / observation ----------------
    logic [RD_WIDTH-1:0] exp_q[$];
    logic [RD_WIDTH-1:0] acc;
    int                  nib_n;
    int                  n_wr;
    int                  gnt_cyc [NUM_REQ];
    int                  frq_cyc;
    logic [31:0]         ev_log;      // one hex digit per event: grant i -> i+1, flush_ack -> F
    logic [NUM_REQ-1:0]  prev_gnt;

    task automatic log_ev(input logic [3:0] code);
        ev_log = {ev_log[27:0], code};
    endtask

    task automatic clear_obs();
        n_wr = 0;
        frq_cyc = 0;
        ev_log = '0;
        for (int i = 0; i < NUM_REQ; i++) gnt_cyc[i] = 0;
    endtask

    // ---------------- reference model ----------------
    // Owner of the write port (-1: none), beats still owed, flush phase,
    // remembered flush request, last burst owner.
    int m_owner;
    int m_left;
    bit m_fl;
    bit m_pend;
    int m_last;
    bit m_ack;
    bit m_err;
    int m_fcnt;

    // flush_done responder
    int fr_cnt;
    int fd_delay;
    bit fd_rand;
    bit next_done;

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_fl    = 1'b0;
        m_pend  = 1'b0;
        m_last  = NUM_REQ - 1;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_fcnt  = 0;
    endtask

    task automatic apply_inputs();
        logic [RD_WIDTH-1:0] w;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (head[i] < tail[i]) begin
                w = words[i][head[i]];
                req[i] = 1'b1;
                req_data[i*WR_WIDTH +: WR_WIDTH] = w[beat[i]*WR_WIDTH +: WR_WIDTH];
            end else begin
                req[i] = 1'b0;
                req_data[i*WR_WIDTH +: WR_WIDTH] = WR_WIDTH'($urandom);
            end
        end
        flush_done = next_done;
    endtask

    task automatic observe_and_check();
        logic [NUM_REQ-1:0]  e_gnt;
        logic                e_wr;
        logic [RD_WIDTH-1:0] w;
        bit                  fin;
        int                  c;

        e_gnt = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
        e_wr  = (m_owner >= 0) && !full;
        check_val("gnt", 32'(gnt), 32'(e_gnt));
        check_val("wr", 32'(wr), 32'(e_wr));
        check_val("beat_take", 32'(beat_take), 32'(e_gnt & {NUM_REQ{e_wr}}));
        check_val("flush_req", 32'(flush_req), 32'(m_fl));
        check_val("flush_ack", 32'(flush_ack), 32'(m_ack));
        check_val("busy", 32'(busy), 32'((m_owner >= 0) || m_fl));
        check_val("flush_err", 32'(flush_err), 32'(m_err));
        if (e_wr) begin
            w = words[m_owner][head[m_owner]];
            check_val("wr_data", 32'(wr_data), 32'(w[beat[m_owner]*WR_WIDTH +: WR_WIDTH]));
        end

        // Word reassembly: first nibble written is the least significant.
        if (wr) begin
            n_wr++;
            acc[nib_n*WR_WIDTH +: WR_WIDTH] = wr_data;
            nib_n++;
            if (nib_n == BEATS) begin
                nib_n = 0;
                check_val("sb_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_val("sb_word", acc, exp_q.pop_front());
            end
        end
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gnt_cyc[i]++;
        if (flush_req) frq_cyc++;
        if (gnt != '0 && prev_gnt == '0) begin
            for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) log_ev(4'(i + 1));
        end
        if (flush_ack) log_ev(4'hF);
        prev_gnt = gnt;

        // Advance the model by one clock.
        fin = 1'b0;
        if (m_fl) begin
            m_fcnt++;
            if (flush_done) fin = 1'b1;
            else if (TMO_EN && m_fcnt == TIMEOUT_CYC) begin
                fin   = 1'b1;
                m_err = 1'b1;
            end
            if (fin) m_fl = 1'b0;
        end else if (m_owner >= 0) begin
            if (!full) begin
                m_left--;
                if (m_left == 0) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end else if (m_pend || flush_in) begin
            m_fl   = 1'b1;
            m_fcnt = 0;
        end else if (req != '0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (m_last + k) % NUM_REQ;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            m_left = BEATS;
            exp_q.push_back(words[m_owner][head[m_owner]]);
        end
        m_pend = flush_in || (m_pend && !fin);
        m_ack  = fin;

        // Producers move to their next nibble / word on each accepted beat.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (beat_take[i]) begin
                beat[i]++;
                if (beat[i] == BEATS) begin
                    beat[i] = 0;
                    head[i]++;
                end
            end
        end

        // FIFO flush responder: one-cycle flush_done after fd_delay cycles.
        if (flush_req) begin
            fr_cnt++;
            if (fr_cnt == 1 && fd_rand)
                fd_delay = (TMO_EN && $urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(1, 6));
        end else begin
            fr_cnt = 0;
        end
        next_done = flush_req && !flush_done && (fr_cnt >= fd_delay);
    endtask

    task automatic tick();
        @(negedge clk);
        observe_and_check();
        @(posedge clk);
        #1;
        apply_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        full = 1'b0;
        flush_in = 1'b0;
        flush_done = 1'b0;
        next_done = 1'b0;
        fr_cnt = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_wr", 32'(wr), 32'd0);
        check_val("rst_beat_take", 32'(beat_take), 32'd0);
        check_val("rst_flush_req", 32'(flush_req), 32'd0);
        check_val("rst_flush_ack", 32'(flush_ack), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_flush_err", 32'(flush_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < NUM_REQ; i++) beat[i] = 0;
        exp_q.delete();
        nib_n = 0;
        prev_gnt = '0;
        apply_inputs();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            tick();
            n++;
            ok = (req == '0) && !busy && !m_fl && !m_pend && (m_owner < 0);
        end
        check_val(tag, 32'(ok), 32'd1);
        tick();
        tick();
    endtask

    task automatic run_until_writes(input string tag, input int target);
        int n;
        n = 0;
        while (n < 100 && n_wr < target) begin
            tick();
            n++;
        end
        check_val(tag, 32'(n_wr), 32'(target));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
            beat[i] = 0;
        end
        fd_rand = 1'b0;
        fd_delay = 3;
        model_reset();

        // Single producer, nibbles 0..7.
        do_reset();
        clear_obs();
        add_word(0, 32'h7654_3210);
        apply_inputs();
        run_until_idle("t1_drain", 100);
        check_val("t1_writes", 32'(n_wr), 32'd8);
        check_val("t1_gnt_cycles", 32'(gnt_cyc[0]), 32'd8);
        check_val("t1_events", ev_log, 32'h1);

        // All four requesting: rotation 0,1,2,3,0,1,2,3.
        do_reset();
        clear_obs();
        for (int i = 0; i < NUM_REQ; i++) begin
            add_word(i, $urandom);
            add_word(i, $urandom);
        end
        apply_inputs();
        run_until_idle("t2_drain", 200);
        check_val("t2_order", ev_log, 32'h1234_1234);
        check_val("t2_writes", 32'(n_wr), 32'd64);
        check_val("t2_gnt0_cycles", 32'(gnt_cyc[0]), 32'd16);

        // FIFO full for 5 cycles after beat 3.
        do_reset();
        clear_obs();
        add_word(2, $urandom);
        apply_inputs();
        run_until_writes("t3_first_half", 4);
        full = 1'b1;
        repeat (5) tick();
        full = 1'b0;
        run_until_idle("t3_drain", 100);
        check_val("t3_writes", 32'(n_wr), 32'd8);
        check_val("t3_gnt2_cycles", 32'(gnt_cyc[2]), 32'd13);

        // Flush pulse mid-burst: burst completes, flush, then producer 2.
        do_reset();
        clear_obs();
        fd_delay = 3;
        add_word(1, $urandom);
        add_word(2, $urandom);
        apply_inputs();
        run_until_writes("t4_two_beats", 2);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        run_until_idle("t4_drain", 200);
        check_val("t4_events", ev_log, 32'h2F3);
        check_val("t4_flush_req_cycles", 32'(frq_cyc), 32'd4);
        check_val("t4_writes", 32'(n_wr), 32'd16);

        // Flush and requests arriving together in IDLE: flush first.
        do_reset();
        clear_obs();
        fd_delay = 2;
        add_word(0, $urandom);
        add_word(1, $urandom);
        flush_in = 1'b1;
        apply_inputs();
        tick();
        flush_in = 1'b0;
        run_until_idle("t5_drain", 200);
        check_val("t5_events", ev_log, 32'hF12);

        // Reset mid-burst: the producer re-sends its whole word afterwards.
        do_reset();
        clear_obs();
        add_word(3, $urandom);
        apply_inputs();
        run_until_writes("t6_three_beats", 3);
        do_reset();
        clear_obs();
        run_until_idle("t6_drain", 100);
        check_val("t6_writes", 32'(n_wr), 32'd8);

`ifdef FLUSH_TIMEOUT_EN
        // flush_done never arrives: timeout after TIMEOUT_CYC cycles.
        do_reset();
        clear_obs();
        fd_delay = 1000;
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        run_until_idle("t7_drain", 100);
        check_val("t7_flush_req_cycles", 32'(frq_cyc), 32'(TIMEOUT_CYC));
        check_val("t7_events", ev_log, 32'hF);
        check_val("t7_err_set", 32'(flush_err), 32'd1);
        repeat (3) tick();
        check_val("t7_err_sticky", 32'(flush_err), 32'd1);
        do_reset();
`endif

        // Randomized traffic, stalls and flushes against the model.
        do_reset();
        clear_obs();
        fd_rand = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 9) == 0) add_word(int'($urandom_range(0, NUM_REQ - 1)), $urandom);
            full = ($urandom_range(0, 3) == 0);
            flush_in = ($urandom_range(0, 40) == 0);
            tick();
        end
        full = 1'b0;
        flush_in = 1'b0;
        run_until_idle("rand_drain", 6000);
        check_val("rand_sb_empty", 32'(exp_q.size()), 32'd0);
        check_val("rand_nibble_align", 32'(nib_n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
